// File: rtl/y86_pkg.sv
// Shared Y86 definitions: instruction codes, register sentinels, D-stage
// register-field selection and the bubble that gets injected into E.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVL = 4'h2;
    localparam logic [3:0] IIRMOVL = 4'h3;
    localparam logic [3:0] IRMMOVL = 4'h4;
    localparam logic [3:0] IMRMOVL = 4'h5;
    localparam logic [3:0] IOPL    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHL  = 4'hA;
    localparam logic [3:0] IPOPL   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

    localparam logic [3:0] BUBBLE_ICODE = INOP;
    localparam logic [3:0] BUBBLE_IFUN  = 4'h0;
    localparam logic [3:0] BUBBLE_REG   = RNONE;

    typedef struct packed {
        logic [3:0] src_a;
        logic [3:0] src_b;
        logic [3:0] dst_e;
        logic [3:0] dst_m;
    } reg_sel_t;

    function automatic reg_sel_t decode_regs(input logic [3:0] icode,
                                             input logic [3:0] ra,
                                             input logic [3:0] rb);
        reg_sel_t sel;
        sel = '{src_a: RNONE, src_b: RNONE, dst_e: RNONE, dst_m: RNONE};
        case (icode)
            IRRMOVL: begin sel.src_a = ra; sel.dst_e = rb; end
            IIRMOVL: sel.dst_e = rb;
            IRMMOVL: begin sel.src_a = ra; sel.src_b = rb; end
            IMRMOVL: begin sel.src_b = rb; sel.dst_m = ra; end
            IOPL:    begin sel.src_a = ra; sel.src_b = rb; sel.dst_e = rb; end
            IPUSHL:  begin sel.src_a = ra; sel.src_b = RRSP; sel.dst_e = RRSP; end
            IPOPL:   begin sel.src_a = RRSP; sel.src_b = RRSP; sel.dst_e = RRSP; sel.dst_m = ra; end
            ICALL:   begin sel.src_b = RRSP; sel.dst_e = RRSP; end
            IRET:    begin sel.src_a = RRSP; sel.src_b = RRSP; sel.dst_e = RRSP; end
            default: ;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/y86_regfile.sv
// NREGS x DATA_W register file: two combinational read ports and two
// clocked write ports, with the M port winning a same-register collision.
module y86_regfile
    import y86_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int NREGS      = 15,
    parameter int INIT_INDEX = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        rd_a_idx,
    output logic [DATA_W-1:0] rd_a_data,
    input  logic [3:0]        rd_b_idx,
    output logic [DATA_W-1:0] rd_b_data,
    input  logic [3:0]        wr_e_idx,
    input  logic [DATA_W-1:0] wr_e_data,
    input  logic [3:0]        wr_m_idx,
    input  logic [DATA_W-1:0] wr_m_data
);

    logic [DATA_W-1:0] regs [NREGS];

    logic a_ok, b_ok, e_ok, m_ok;
    assign a_ok = (rd_a_idx != RNONE) && (int'(rd_a_idx) < NREGS);
    assign b_ok = (rd_b_idx != RNONE) && (int'(rd_b_idx) < NREGS);
    assign e_ok = (wr_e_idx != RNONE) && (int'(wr_e_idx) < NREGS);
    assign m_ok = (wr_m_idx != RNONE) && (int'(wr_m_idx) < NREGS);

    assign rd_a_data = a_ok ? regs[rd_a_idx] : '0;
    assign rd_b_data = b_ok ? regs[rd_b_idx] : '0;

    // M is written after E so the later non-blocking update takes the collision
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= (INIT_INDEX != 0) ? DATA_W'(i) : '0;
            end
        end else begin
            if (e_ok) regs[wr_e_idx] <= wr_e_data;
            if (m_ok) regs[wr_m_idx] <= wr_m_data;
        end
    end

endmodule

// File: rtl/y86_decode_fwd.sv
// Y86 decode stage: register selection, E/M/W forwarding, load-use
// detection and the D/E pipeline register.
module y86_decode_fwd
    import y86_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int NREGS      = 15,
    parameter int INIT_INDEX = 1,
    parameter int FWD_EN     = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              d_valid_i,
    input  logic [3:0]        d_icode_i,
    input  logic [3:0]        d_ifun_i,
    input  logic [3:0]        d_rA_i,
    input  logic [3:0]        d_rB_i,
    input  logic [DATA_W-1:0] d_valC_i,
    input  logic [DATA_W-1:0] d_valP_i,
    input  logic              bubble_i,
    input  logic [3:0]        e_dstE_i,
    input  logic [DATA_W-1:0] e_valE_i,
    input  logic [3:0]        e_dstM_i,
    input  logic [3:0]        m_dstE_i,
    input  logic [DATA_W-1:0] m_valE_i,
    input  logic [3:0]        m_dstM_i,
    input  logic [DATA_W-1:0] m_valM_i,
    input  logic [3:0]        w_dstE_i,
    input  logic [DATA_W-1:0] w_valE_i,
    input  logic [3:0]        w_dstM_i,
    input  logic [DATA_W-1:0] w_valM_i,
    output logic              stall_o,
    output logic              e_valid_o,
    output logic [3:0]        e_icode_o,
    output logic [3:0]        e_ifun_o,
    output logic [DATA_W-1:0] e_valC_o,
    output logic [DATA_W-1:0] e_valA_o,
    output logic [DATA_W-1:0] e_valB_o,
    output logic [3:0]        e_dstE_o,
    output logic [3:0]        e_dstM_o,
    output logic [3:0]        e_srcA_o,
    output logic [3:0]        e_srcB_o
);

    reg_sel_t          sel;
    logic [DATA_W-1:0] rf_a, rf_b, fwd_a, fwd_b, val_a;
    logic              load_use;
    logic [3:0]        fwd_dst [5];
    logic [DATA_W-1:0] fwd_val [5];

    assign sel = decode_regs(d_icode_i, d_rA_i, d_rB_i);

    y86_regfile #(
        .DATA_W    (DATA_W),
        .NREGS     (NREGS),
        .INIT_INDEX(INIT_INDEX)
    ) u_regfile (
        .clk      (clk_i),
        .rst      (rst_i),
        .rd_a_idx (sel.src_a),
        .rd_a_data(rf_a),
        .rd_b_idx (sel.src_b),
        .rd_b_data(rf_b),
        .wr_e_idx (w_dstE_i),
        .wr_e_data(w_valE_i),
        .wr_m_idx (w_dstM_i),
        .wr_m_data(w_valM_i)
    );

    // Index 0 is the youngest producer and must win
    assign fwd_dst[0] = e_dstE_i;  assign fwd_val[0] = e_valE_i;
    assign fwd_dst[1] = m_dstM_i;  assign fwd_val[1] = m_valM_i;
    assign fwd_dst[2] = m_dstE_i;  assign fwd_val[2] = m_valE_i;
    assign fwd_dst[3] = w_dstM_i;  assign fwd_val[3] = w_valM_i;
    assign fwd_dst[4] = w_dstE_i;  assign fwd_val[4] = w_valE_i;

    // Scanning oldest-to-youngest lets the youngest match overwrite the rest
    always_comb begin
        fwd_a = rf_a;
        fwd_b = rf_b;
        if (FWD_EN != 0) begin
            for (int i = 4; i >= 0; i--) begin
                if (sel.src_a != RNONE && fwd_dst[i] == sel.src_a) fwd_a = fwd_val[i];
                if (sel.src_b != RNONE && fwd_dst[i] == sel.src_b) fwd_b = fwd_val[i];
            end
        end
    end

    assign val_a = (d_icode_i == ICALL || d_icode_i == IJXX) ? d_valP_i : fwd_a;

    assign load_use = d_valid_i && (e_dstM_i != RNONE) &&
                      (e_dstM_i == sel.src_a || e_dstM_i == sel.src_b);
    assign stall_o  = load_use;

    always_ff @(posedge clk_i) begin
        if (rst_i || bubble_i || load_use) begin
            e_valid_o <= 1'b0;
            e_icode_o <= BUBBLE_ICODE;
            e_ifun_o  <= BUBBLE_IFUN;
            e_valC_o  <= '0;
            e_valA_o  <= '0;
            e_valB_o  <= '0;
            e_dstE_o  <= BUBBLE_REG;
            e_dstM_o  <= BUBBLE_REG;
            e_srcA_o  <= BUBBLE_REG;
            e_srcB_o  <= BUBBLE_REG;
        end else begin
            e_valid_o <= d_valid_i;
            e_icode_o <= d_icode_i;
            e_ifun_o  <= d_ifun_i;
            e_valC_o  <= d_valC_i;
            e_valA_o  <= val_a;
            e_valB_o  <= fwd_b;
            e_dstE_o  <= sel.dst_e;
            e_dstM_o  <= sel.dst_m;
            e_srcA_o  <= sel.src_a;
            e_srcB_o  <= sel.src_b;
        end
    end

endmodule

// File: doc/y86_decode_fwd.md
Name: y86_decode_fwd

Overview:
- Pipelined-generation decode stage for the Y86 core.
- Selects srcA/srcB/dstE/dstM per icode and reads a parametrised 2-read/2-write register file.
- Resolves data hazards by forwarding from the E, M and W stages, and detects load-use hazards (stall plus bubble).
- Registers its results into the D/E pipeline register; sits between fetch and execute.

Parameters:
DATA_W, 64, data path width for registers, valC, valP and forwarded values
NREGS, 15, architectural registers stored (indices 0..NREGS-1); 4'hF always means "none"
INIT_INDEX, 1, reset contents: 1 = reg[i] gets i, 0 = all zero
FWD_EN, 1, 1 = forwarding network active; 0 = read register file only (for debug/compare)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
d_valid_i  in  1  D-stage holds a real instruction
d_icode_i  in  4  instruction code
d_ifun_i  in  4  function code
d_rA_i  in  4  rA field
d_rB_i  in  4  rB field
d_valC_i  in  DATA_W  constant word
d_valP_i  in  DATA_W  next PC
bubble_i  in  1  flush (mispredict/ret); inject a bubble into E
e_dstE_i  in  4  dstE of the instruction now in E (already cnd-gated)
e_valE_i  in  DATA_W  ALU result in E
e_dstM_i  in  4  dstM of the instruction now in E (load-use check)
m_dstE_i  in  4  M-stage dstE
m_valE_i  in  DATA_W  M-stage valE
m_dstM_i  in  4  M-stage dstM
m_valM_i  in  DATA_W  M-stage memory data
w_dstE_i  in  4  write-back dstE; also register file write port E
w_valE_i  in  DATA_W  write-back valE
w_dstM_i  in  4  write-back dstM; also register file write port M
w_valM_i  in  DATA_W  write-back valM
stall_o  out  1  load-use hazard; fetch and D must hold
e_valid_o  out  1  E register valid
e_icode_o  out  4  E icode
e_ifun_o  out  4  E ifun
e_valC_o  out  DATA_W  E valC
e_valA_o  out  DATA_W  E valA
e_valB_o  out  DATA_W  E valB
e_dstE_o  out  4  E dstE
e_dstM_o  out  4  E dstM
e_srcA_o  out  4  E srcA
e_srcB_o  out  4  E srcB

Behaviour:
- Source selection:
  - srcA = rA for RRMOVL, RMMOVL, ALU and PUSHL.
  - srcA = 4 for POPL and RET.
  - srcA = F otherwise.
  - srcB = rB for RMMOVL, MRMOVL and ALU.
  - srcB = 4 for PUSHL, POPL, CALL and RET.
  - srcB = F otherwise.
- Destination selection:
  - dstE = rB for RRMOVL, IRMOVL and ALU.
  - dstE = 4 for PUSHL, POPL, CALL and RET.
  - dstM = rA for MRMOVL and POPL.
  - All other cases: F.
- valA: CALL and JXX select d_valP_i. Otherwise use the forwarding chain.
- Forwarding chain (applies when src != F and FWD_EN = 1), priority first-match:
  e_dstE, m_dstM, m_dstE, w_dstM, w_dstE, then register file.
- Read values:
  - src = F or src >= NREGS reads 0.
  - The register file read is combinational. A same-cycle W write is covered by the forward path, not by write-first RAM.
- Register file writes at posedge:
  - Write to w_dstE and w_dstM when the index is not F and is < NREGS.
  - If both target the same register, valM wins.
  - Writes occur regardless of stall_o or bubble_i.
- Load-use hazard: e_dstM_i != F and (e_dstM_i == srcA or e_dstM_i == srcB), with d_valid_i = 1. This asserts stall_o combinationally.
- E register update at posedge, priority top-down:
  - rst_i: bubble.
  - bubble_i or load-use: bubble.
  - Else: load the D values, including e_valid_o = d_valid_i.
  - Bubble = valid 0, icode NOP, ifun 0, dst/src F, data 0.
- No hold state on E. A downstream stall is not supported in this generation.
- Reset:
  - All E outputs take the bubble values.
  - Register file loads the INIT_INDEX pattern.
  - W writes presented during reset are discarded.
  - stall_o is combinational, and reads 0 only if the inputs give no hazard.
  - Reset mid-stream drops any in-flight D instruction.
- Latency: 1 cycle from D inputs to E outputs. Forwarding is zero-cycle.
- Simultaneous bubble_i and load-use: E gets a bubble and stall_o = 1. Fetch handles priority.

Decomposition:
- Shared package y86_pkg: icode localparams (NOP..POPL), RNONE = 4'hF, RRSP = 4'h4, and the bubble constants.
- Sub-module y86_regfile: parametrised NREGS x DATA_W, 2 async read ports, 2 sync write ports (M-over-E priority), synchronous reset with the INIT_INDEX pattern.
- Decode select, forwarding and the pipeline register stay in the top level.

Test Plan:
- Reset with INIT_INDEX = 1, then ALU rA = 3, rB = 5 with no forwarding → e_valA_o = 3, e_valB_o = 5, e_dstE_o = 5, one cycle later.
- Forward priority: rA = 2 with e_dstE = 2 (valE 0xAA), m_dstM = 2 (valM 0xBB) and w_dstE = 2 (0xCC) → valA = 0xAA. Drop e_dstE → 0xBB. Drop m_dstM → 0xCC.
- Load-use: e_dstM_i = 1, D = ALU rA = 1 → stall_o = 1 and E is a bubble. Next cycle with e_dstM = F and m_dstM = 1 (0x77) → valA = 0x77.
- Dual write collision: w_dstE = w_dstM = 6, valE = 0x11, valM = 0x22 → a later read of reg 6 returns 0x22.
- CALL with d_valP = 0x40 and rsp = 4 → e_valA_o = 0x40, e_valB_o = 4, e_dstE_o = 4, e_srcA_o = F.
- bubble_i during a valid IRMOVL → e_valid_o = 0, e_icode_o = NOP, e_dstE_o = F.
- rst_i asserted mid-stream while w_dstE = 3 → reg 3 stays 3.
